kernel_out_monitor: RTL and testbench
=====================================

// Module: kernel_out_monitor
// PURPOSE
//  Downstream consumer of the HLS kernel output FIFO stream (E_out_din/E_out_write).
//  Per kernel run it compacts every output word into a 32-bit MISR signature and counts words and run cycles.
//  After ap_done it serialises a 21-nibble report onto the 4-bit data_out/data_valid board pins.
//  Sits in the benchmark wrapper between the kernel and the output pins, replacing the per-word xor reduction.
// PARAMETERS
//  DATA_WIDTH   32            kernel output word width (MISR width equals this)
//  WCNT_WIDTH   16            output-word counter width, saturating
//  CCNT_WIDTH   32            run-cycle counter width, saturating
//  MISR_POLY    32'h04C11DB7  MISR feedback polynomial
//  MISR_SEED    32'hFFFFFFFF  MISR value loaded at run start
// PORTS
//  ap_clk      in   1           single clock domain
//  ap_rst_n    in   1           synchronous, active-low reset
//  ap_start    in   1           kernel start level; a run begins on its rising edge
//  ap_done     in   1           kernel done pulse, 1 cycle
//  out_din     in   DATA_WIDTH  kernel output word
//  out_write   in   1           out_din valid this cycle
//  out_full_n  out  1           1 = word accepted; 0 only in DUMP
//  data_out    out  4           report nibble; 0 when data_valid=0
//  data_valid  out  1           data_out carries a report nibble
//  busy        out  1           1 in RUN or DUMP
// BEHAVIOUR
//  Reset (ap_rst_n=0 sampled on a clock edge), including mid-run or mid-dump: state=IDLE.
//   - data_out=0, data_valid=0, busy=0, out_full_n=1.
//   - misr=MISR_SEED, wcnt=0, ccnt=0, start_pend=0, nibble index=0, ap_start history reg=0.
//  FSM IDLE -> RUN -> DUMP -> IDLE.
//   IDLE: a start edge (ap_start=1 and previous ap_start=0), or start_pend=1, moves to RUN next cycle.
//     On entry: misr=SEED, wcnt=0, ccnt=0, start_pend cleared.
//     Writes and ap_done in IDLE are ignored.
//     A start edge and ap_done in the same IDLE cycle: start wins.
//   RUN: every cycle, ccnt+=1, saturating at all-ones.
//     On out_write: misr <= {misr[30:0],1'b0} ^ (misr[31] ? POLY : 0) ^ out_din; wcnt+=1, saturating.
//     ap_done sampled -> DUMP next cycle.
//     A write in the ap_done cycle is included, and that cycle is counted in ccnt.
//     Start edges in RUN are ignored.
//   DUMP: 21 consecutive cycles with data_valid=1, data_out = report nibble, then IDLE.
//     Report order, MSB nibble first: 4'hA sync, misr[31:0] (8 nibbles), wcnt[15:0] (4), ccnt[31:0] (8).
//     First nibble is registered; it appears the cycle after ap_done is sampled.
//     out_full_n=0 in DUMP; writes are dropped and do not alter the report.
//     A start edge during DUMP sets start_pend; the next RUN begins 1 cycle after DUMP ends.
//  All outputs are registered; no combinational input-to-output path.
// STRUCTURE
//  Package kmon_pkg holds:
//   - state encoding (IDLE/RUN/DUMP)
//   - REPORT_NIBBLES=21 and SYNC_NIBBLE=4'hA
//   - default MISR_POLY and MISR_SEED
//  One sub-module, kmon_misr:
//   - parameterised MISR register with seed-load and update enables
//  FSM, counters and the 80-bit report shift register stay in kernel_out_monitor.
// TESTING
//  1 Reset, then start edge; one write of din=0 in RUN cycle 3; ap_done in RUN cycle 10
//    -> report A,F,B,3,E,E,2,4,9, 0,0,0,1, 0,0,0,0,0,0,0,A (misr=FB3EE249, wcnt=1, ccnt=10).
//  2 Start edge, no writes, ap_done in RUN cycle 1
//    -> report A,F,F,F,F,F,F,F,F, 0,0,0,0, 0,0,0,0,0,0,0,1; data_valid low again after 21 cycles.
//  3 70000 writes in one run
//    -> wcnt nibbles F,F,F,F (saturated); out_full_n stays 1 throughout RUN.
//  4 Start edge during DUMP cycle 5
//    -> DUMP completes all 21 nibbles, then RUN begins exactly 1 cycle later with cleared counters.
//  5 ap_rst_n=0 during DUMP nibble 7
//    -> next cycle data_valid=0, data_out=0, busy=0; ap_done later, without a start edge, produces no report.
//  6 Writes and ap_done in IDLE
//    -> no data_valid; a following run reports misr=FFFFFFFF, wcnt=0 when no writes occur in it.

Source files
------------

// File: rtl/kmon_pkg.sv
// Shared state encoding and report constants for the kernel output monitor.
package kmon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUMP = 2'd2
    } state_t;

    localparam int          REPORT_NIBBLES    = 21;
    localparam logic [3:0]  SYNC_NIBBLE       = 4'hA;
    localparam logic [31:0] DEFAULT_MISR_POLY = 32'h04C11DB7;
    localparam logic [31:0] DEFAULT_MISR_SEED = 32'hFFFFFFFF;

endpackage

// File: rtl/kmon_misr.sv
// Multiple-input signature register: folds one data word per update into a
// polynomial-feedback shift register. Exposes the post-update value.
module kmon_misr
    import kmon_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = DEFAULT_MISR_POLY,
    parameter logic [WIDTH-1:0] SEED  = DEFAULT_MISR_SEED
) (
    input  logic             i_clk,
    input  logic             i_rstN,
    input  logic             i_load,
    input  logic             i_update,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_misrNext
);

    logic [WIDTH-1:0] r_misr;
    logic [WIDTH-1:0] w_next;

    // The next value is exported so the report can capture a word written
    // in the same cycle the run finishes.
    always_comb begin
        w_next = r_misr;
        if (i_update) begin
            w_next = {r_misr[WIDTH-2:0], 1'b0} ^ (r_misr[WIDTH-1] ? POLY : '0) ^ i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstN || i_load) begin
            r_misr <= SEED;
        end else begin
            r_misr <= w_next;
        end
    end

    assign o_misrNext = w_next;

endmodule

// File: rtl/kernel_out_monitor.sv
// Consumes the kernel output stream, builds a per-run signature plus word and
// cycle counts, and serialises the result as a nibble report after ap_done.
module kernel_out_monitor
    import kmon_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    WCNT_WIDTH = 16,
    parameter int                    CCNT_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] MISR_POLY  = DEFAULT_MISR_POLY,
    parameter logic [DATA_WIDTH-1:0] MISR_SEED  = DEFAULT_MISR_SEED
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    input  logic                  ap_done,
    input  logic [DATA_WIDTH-1:0] out_din,
    input  logic                  out_write,
    output logic                  out_full_n,
    output logic [3:0]            data_out,
    output logic                  data_valid,
    output logic                  busy
);

    localparam int REPORT_BITS = DATA_WIDTH + WCNT_WIDTH + CCNT_WIDTH;
    localparam int NUM_NIBBLES = 1 + REPORT_BITS / 4;
    localparam int IDX_W       = $clog2(NUM_NIBBLES);

    state_t                  r_state;
    logic                    r_startPrev;
    logic                    r_startPend;
    logic [WCNT_WIDTH-1:0]   r_wcnt;
    logic [CCNT_WIDTH-1:0]   r_ccnt;
    logic [REPORT_BITS-1:0]  r_report;
    logic [IDX_W-1:0]        r_nibIdx;
    logic [3:0]              r_dataOut;
    logic                    r_dataValid;
    logic                    r_busy;
    logic                    r_fullN;

    logic                    w_startEdge;
    logic                    w_runEntry;
    logic                    w_misrUpdate;
    logic [DATA_WIDTH-1:0]   w_misrNext;
    logic [WCNT_WIDTH-1:0]   w_wcntNext;
    logic [CCNT_WIDTH-1:0]   w_ccntNext;

    assign w_startEdge  = ap_start & ~r_startPrev;
    assign w_runEntry   = (r_state == ST_IDLE) && (w_startEdge || r_startPend);
    assign w_misrUpdate = (r_state == ST_RUN) && out_write;

    // Counter next values include the current cycle so the ap_done cycle is reported.
    always_comb begin
        w_wcntNext = r_wcnt;
        if (w_misrUpdate && !(&r_wcnt)) begin
            w_wcntNext = r_wcnt + WCNT_WIDTH'(1);
        end
        w_ccntNext = r_ccnt;
        if (!(&r_ccnt)) begin
            w_ccntNext = r_ccnt + CCNT_WIDTH'(1);
        end
    end

    kmon_misr #(
        .WIDTH (DATA_WIDTH),
        .POLY  (MISR_POLY),
        .SEED  (MISR_SEED)
    ) u_misr (
        .i_clk      (ap_clk),
        .i_rstN     (ap_rst_n),
        .i_load     (w_runEntry),
        .i_update   (w_misrUpdate),
        .i_din      (out_din),
        .o_misrNext (w_misrNext)
    );

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state     <= ST_IDLE;
            r_startPrev <= 1'b0;
            r_startPend <= 1'b0;
            r_wcnt      <= '0;
            r_ccnt      <= '0;
            r_report    <= '0;
            r_nibIdx    <= '0;
            r_dataOut   <= 4'h0;
            r_dataValid <= 1'b0;
            r_busy      <= 1'b0;
            r_fullN     <= 1'b1;
        end else begin
            r_startPrev <= ap_start;
            case (r_state)
                ST_IDLE: begin
                    if (w_runEntry) begin
                        r_state     <= ST_RUN;
                        r_wcnt      <= '0;
                        r_ccnt      <= '0;
                        r_startPend <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_wcnt <= w_wcntNext;
                    r_ccnt <= w_ccntNext;
                    if (ap_done) begin
                        r_state     <= ST_DUMP;
                        r_report    <= {w_misrNext, w_wcntNext, w_ccntNext};
                        r_nibIdx    <= '0;
                        r_dataOut   <= SYNC_NIBBLE;
                        r_dataValid <= 1'b1;
                        r_fullN     <= 1'b0;
                    end
                end
                ST_DUMP: begin
                    if (w_startEdge) begin
                        r_startPend <= 1'b1;
                    end
                    // r_nibIdx tracks the nibble currently on the pins.
                    if (r_nibIdx == IDX_W'(NUM_NIBBLES - 1)) begin
                        r_state     <= ST_IDLE;
                        r_dataOut   <= 4'h0;
                        r_dataValid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_fullN     <= 1'b1;
                    end else begin
                        r_dataOut <= r_report[REPORT_BITS-1 -: 4];
                        r_report  <= r_report << 4;
                        r_nibIdx  <= r_nibIdx + IDX_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_out   = r_dataOut;
    assign data_valid = r_dataValid;
    assign busy       = r_busy;
    assign out_full_n = r_fullN;

endmodule

// File: tb/tb_kernel_out_monitor.sv
// Randomised scoreboard bench for kernel_out_monitor: drivers push expected
// report nibbles, a negedge monitor pops and compares them.
module tb_kernel_out_monitor;
    import kmon_pkg::*;

    localparam int MODE_RANDOM = 0;
    localparam int MODE_NONE   = 1;
    localparam int MODE_ZERO3  = 2;
    localparam int MODE_ALL    = 3;

    localparam int DUMP_DRAIN = 0;
    localparam int DUMP_START = 1;
    localparam int DUMP_RESET = 2;

    logic        ap_clk     = 1'b0;
    logic        ap_rst_n   = 1'b0;
    logic        ap_start   = 1'b0;
    logic        ap_done    = 1'b0;
    logic [31:0] out_din    = '0;
    logic        out_write  = 1'b0;
    logic        out_full_n;
    logic [3:0]  data_out;
    logic        data_valid;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  expQ[$];
    bit          monitorOn = 0;
    bit          gDoneWithStart = 0;

    always #5 ap_clk = ~ap_clk;

    kernel_out_monitor dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .ap_start   (ap_start),
        .ap_done    (ap_done),
        .out_din    (out_din),
        .out_write  (out_write),
        .out_full_n (out_full_n),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy)
    );

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference signature step written as plain shift/xor arithmetic.
    function automatic logic [31:0] misrStep(input logic [31:0] m, input logic [31:0] w);
        logic [31:0] fb;
        fb = (m >> 31) != 0 ? DEFAULT_MISR_POLY : 32'h0;
        return (m << 1) ^ fb ^ w;
    endfunction

    task automatic pushReport(input logic [31:0] misr, input longint words, input longint cycles);
        logic [83:0] rep;
        logic [15:0] wc;
        logic [31:0] cc;
        wc  = (words > 65535) ? 16'hFFFF : 16'(words);
        cc  = (cycles > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(cycles);
        rep = {SYNC_NIBBLE, misr, wc, cc};
        for (int i = REPORT_NIBBLES - 1; i >= 0; i--) begin
            expQ.push_back(rep[i*4 +: 4]);
        end
    endtask

    always @(negedge ap_clk) begin
        if (monitorOn) begin
            if (data_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedValid: got data_valid=1 data_out=%0h, expected no report at %0t", data_out, $time);
                end else begin
                    checkOutput("reportNibble", data_out, expQ.pop_front());
                end
            end else begin
                checkOutput("idleDataOut", {data_valid, data_out}, 5'h0);
            end
        end
    end

    task automatic applyStimulus(input int runCycles, input int mode, input bit issueStart,
                                 input int dumpAction, input int dumpArg);
        logic [31:0] mMisr;
        longint      mWords;
        longint      mCycles;
        bit          fullOk;
        bit          busyOk;
        bit          wr;
        mMisr   = DEFAULT_MISR_SEED;
        mWords  = 0;
        mCycles = 0;
        fullOk  = 1;
        busyOk  = 1;
        if (issueStart) begin
            ap_start  = 1'b1;
            ap_done   = gDoneWithStart;
            out_write = 1'($urandom_range(0, 1));
            out_din   = $urandom;
            step();
            ap_start  = 1'b0;
            ap_done   = 1'b0;
            out_write = 1'b0;
        end
        for (int c = 1; c <= runCycles; c++) begin
            if (out_full_n !== 1'b1) fullOk = 0;
            if (busy !== 1'b1) busyOk = 0;
            case (mode)
                MODE_RANDOM: wr = 1'($urandom_range(0, 1));
                MODE_ZERO3:  wr = (c == 3);
                MODE_ALL:    wr = 1'b1;
                default:     wr = 1'b0;
            endcase
            out_write = wr;
            out_din   = (mode == MODE_ZERO3) ? 32'h0 : $urandom;
            if (wr) begin
                mMisr = misrStep(mMisr, out_din);
                mWords++;
            end
            mCycles++;
            ap_start = (mode == MODE_RANDOM && c != runCycles) ? 1'($urandom_range(0, 1)) : 1'b0;
            ap_done  = (c == runCycles);
            if (c == runCycles) pushReport(mMisr, mWords, mCycles);
            step();
        end
        ap_done   = 1'b0;
        ap_start  = 1'b0;
        out_write = 1'b0;
        checkOutput("runFullN", fullOk, 1);
        checkOutput("runBusy", busyOk, 1);
        checkOutput("dumpFullN", out_full_n, 0);
        checkOutput("dumpBusy", busy, 1);

        if (dumpAction == DUMP_START) begin
            for (int d = 1; d <= REPORT_NIBBLES; d++) begin
                ap_start  = (d == dumpArg);
                out_write = 1'($urandom_range(0, 1));
                out_din   = $urandom;
                step();
            end
            ap_start  = 1'b0;
            out_write = 1'b0;
            checkOutput("pendGapBusy", busy, 0);
            checkOutput("pendGapValid", data_valid, 0);
            step();
            checkOutput("pendRunBusy", busy, 1);
            checkOutput("pendRunFullN", out_full_n, 1);
        end else if (dumpAction == DUMP_RESET) begin
            repeat (dumpArg - 1) step();
            ap_rst_n = 1'b0;
            step();
            expQ.delete();
            checkOutput("rstDumpValid", data_valid, 0);
            checkOutput("rstDumpData", data_out, 0);
            checkOutput("rstDumpBusy", busy, 0);
            checkOutput("rstDumpFullN", out_full_n, 1);
            ap_rst_n = 1'b1;
        end else begin
            int guard;
            guard = 0;
            while ((data_valid === 1'b1 || expQ.size() != 0) && guard < 40) begin
                out_write = 1'($urandom_range(0, 1));
                out_din   = $urandom;
                step();
                guard++;
            end
            out_write = 1'b0;
            checkOutput("dumpLength", guard, REPORT_NIBBLES);
            checkOutput("postDumpBusy", busy, 0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ap_rst_n = 1'b0;
        repeat (3) step();
        checkOutput("rstDataOut", data_out, 0);
        checkOutput("rstValid", data_valid, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstFullN", out_full_n, 1);
        ap_rst_n = 1'b1;
        step();
        monitorOn = 1;

        $display("[TB] single zero write, done in cycle 10");
        applyStimulus(10, MODE_ZERO3, 1, DUMP_DRAIN, 0);

        $display("[TB] no writes, done in cycle 1");
        applyStimulus(1, MODE_NONE, 1, DUMP_DRAIN, 0);

        $display("[TB] random runs");
        for (int r = 0; r < 6; r++) begin
            applyStimulus(int'($urandom_range(1, 60)), MODE_RANDOM, 1, DUMP_DRAIN, 0);
            repeat (int'($urandom_range(0, 3))) step();
        end

        $display("[TB] start edge during dump");
        applyStimulus(8, MODE_RANDOM, 1, DUMP_START, 5);
        applyStimulus(3, MODE_NONE, 0, DUMP_DRAIN, 0);

        $display("[TB] reset during dump");
        applyStimulus(6, MODE_RANDOM, 1, DUMP_RESET, 7);
        step();
        ap_done = 1'b1;
        step();
        ap_done = 1'b0;
        repeat (30) step();
        checkOutput("noRunAfterReset", busy, 0);

        $display("[TB] idle writes and done ignored");
        for (int i = 0; i < 10; i++) begin
            out_write = 1'b1;
            out_din   = $urandom;
            ap_done   = 1'($urandom_range(0, 1));
            step();
        end
        out_write = 1'b0;
        ap_done   = 1'b0;
        checkOutput("idleNoBusy", busy, 0);
        gDoneWithStart = 1;
        applyStimulus(5, MODE_NONE, 1, DUMP_DRAIN, 0);
        gDoneWithStart = 0;

        $display("[TB] word counter saturation");
        applyStimulus(70000, MODE_ALL, 1, DUMP_DRAIN, 0);

        repeat (5) step();
        checkOutput("queueEmpty", expQ.size(), 0);
        monitorOn = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
